// File: rtl/tl_buffer_if.sv
// TileLink beat types and the TL_BUS channel bundle.
// Master modport faces the upstream agent; Slave modport faces the downstream agent.
package tl_pkg;
    typedef struct packed {
        logic [2:0]  opcode;
        logic [3:0]  source;
        logic [31:0] address;
        logic [31:0] data;
    } tl_a_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [3:0]  source;
        logic [31:0] address;
    } tl_b_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [3:0]  source;
        logic [31:0] address;
        logic [31:0] data;
    } tl_c_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [3:0]  source;
        logic [3:0]  sink;
        logic [31:0] data;
    } tl_d_t;

    typedef struct packed {
        logic [7:0] sink;
    } tl_e_t;
endpackage

interface TL_BUS;
    import tl_pkg::*;

    logic  a_valid;
    logic  a_ready;
    tl_a_t a_bits;
    logic  b_valid;
    logic  b_ready;
    tl_b_t b_bits;
    logic  c_valid;
    logic  c_ready;
    tl_c_t c_bits;
    logic  d_valid;
    logic  d_ready;
    tl_d_t d_bits;
    logic  e_valid;
    logic  e_ready;
    tl_e_t e_bits;

    modport Master (
        input  a_valid, a_bits, output a_ready,
        output b_valid, b_bits, input  b_ready,
        input  c_valid, c_bits, output c_ready,
        output d_valid, d_bits, input  d_ready,
        input  e_valid, e_bits, output e_ready
    );

    modport Slave (
        output a_valid, a_bits, input  a_ready,
        input  b_valid, b_bits, output b_ready,
        output c_valid, c_bits, input  c_ready,
        input  d_valid, d_bits, output d_ready,
        output e_valid, e_bits, input  e_ready
    );
endinterface

// File: rtl/tl_buffer.sv
// Five-channel TileLink buffer: one FIFO per channel, depth 0 = wire.
// Define TL_BUFFER_FLOW_EN to let empty FIFOs pass beats through in the same cycle.
module tl_buffer_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic up_valid,
    output logic up_ready,
    input  T     up_bits,
    output logic dn_valid,
    input  logic dn_ready,
    output T     dn_bits
);
    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
        assign dn_valid = up_valid;
        assign dn_bits  = up_bits;
        assign up_ready = dn_ready;
    end else begin : g_fifo
        localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
        localparam int unsigned CW = $clog2(DEPTH + 1);

        T               mem [DEPTH];
        logic [PW-1:0]  wr_ptr;
        logic [PW-1:0]  rd_ptr;
        logic [PW-1:0]  wr_next;
        logic [PW-1:0]  rd_next;
        logic [CW-1:0]  count;
        logic           full;
        logic           empty;
        logic           push;
        logic           pop;

        assign full    = (count == CW'(DEPTH));
        assign empty   = (count == '0);
        assign wr_next = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
        assign rd_next = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);

        always_comb begin
            up_ready = 1'b0;
            dn_valid = 1'b0;
            dn_bits  = mem[rd_ptr];
            push     = 1'b0;
            pop      = 1'b0;
`ifdef TL_BUFFER_FLOW_EN
            // An empty FIFO hands the upstream beat straight through;
            // it is only stored when downstream does not take it.
            up_ready = !rst_i && (!full || dn_ready);
            dn_valid = !rst_i && (!empty || up_valid);
            if (empty) begin
                dn_bits = up_bits;
            end
            push = up_valid && up_ready && !(empty && dn_ready);
            pop  = dn_valid && dn_ready && !empty;
`else
            up_ready = !rst_i && !full;
            dn_valid = !rst_i && !empty;
            push     = up_valid && up_ready;
            pop      = dn_valid && dn_ready;
`endif
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_next;
                end
                if (pop) begin
                    rd_ptr <= rd_next;
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end

        // Storage carries no reset; bits are ignored while valid is low.
        always_ff @(posedge clk_i) begin
            if (push) begin
                mem[wr_ptr] <= up_bits;
            end
        end
    end
endmodule

module tl_buffer
    import tl_pkg::*;
#(
    parameter int unsigned A_DEPTH = 2,
    parameter int unsigned B_DEPTH = 2,
    parameter int unsigned C_DEPTH = 2,
    parameter int unsigned D_DEPTH = 2,
    parameter int unsigned E_DEPTH = 2
) (
    input logic    clk_i,
    input logic    rst_i,
    TL_BUS.Master  in,
    TL_BUS.Slave   out
);
    tl_buffer_fifo #(.DEPTH(A_DEPTH), .T(tl_a_t)) u_a (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .up_valid (in.a_valid),
        .up_ready (in.a_ready),
        .up_bits  (in.a_bits),
        .dn_valid (out.a_valid),
        .dn_ready (out.a_ready),
        .dn_bits  (out.a_bits)
    );

    // B and D flow back from the slave side toward the master side.
    tl_buffer_fifo #(.DEPTH(B_DEPTH), .T(tl_b_t)) u_b (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .up_valid (out.b_valid),
        .up_ready (out.b_ready),
        .up_bits  (out.b_bits),
        .dn_valid (in.b_valid),
        .dn_ready (in.b_ready),
        .dn_bits  (in.b_bits)
    );

    tl_buffer_fifo #(.DEPTH(C_DEPTH), .T(tl_c_t)) u_c (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .up_valid (in.c_valid),
        .up_ready (in.c_ready),
        .up_bits  (in.c_bits),
        .dn_valid (out.c_valid),
        .dn_ready (out.c_ready),
        .dn_bits  (out.c_bits)
    );

    tl_buffer_fifo #(.DEPTH(D_DEPTH), .T(tl_d_t)) u_d (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .up_valid (out.d_valid),
        .up_ready (out.d_ready),
        .up_bits  (out.d_bits),
        .dn_valid (in.d_valid),
        .dn_ready (in.d_ready),
        .dn_bits  (in.d_bits)
    );

    tl_buffer_fifo #(.DEPTH(E_DEPTH), .T(tl_e_t)) u_e (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .up_valid (in.e_valid),
        .up_ready (in.e_ready),
        .up_bits  (in.e_bits),
        .dn_valid (out.e_valid),
        .dn_ready (out.e_ready),
        .dn_bits  (out.e_bits)
    );
endmodule

// File: tb/tb_tl_buffer.sv
// Scoreboard bench for tl_buffer: A=4, B=2, C=2, D=2, E=0 (wire).
// Expected timing adapts when TL_BUFFER_FLOW_EN is defined.
module tb_tl_buffer;
    import tl_pkg::*;

`ifdef TL_BUFFER_FLOW_EN
    localparam bit FLOW = 1'b1;
`else
    localparam bit FLOW = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;

    tl_a_t qa[$];
    tl_b_t qb[$];
    tl_c_t qc[$];
    tl_d_t qd[$];
    tl_e_t qe[$];

    TL_BUS bus_in ();
    TL_BUS bus_out ();

    tl_buffer #(
        .A_DEPTH (4),
        .B_DEPTH (2),
        .C_DEPTH (2),
        .D_DEPTH (2),
        .E_DEPTH (0)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .in    (bus_in),
        .out   (bus_out)
    );

    always #5 clk = ~clk;

    function automatic tl_a_t mk_a(logic [31:0] d);
        tl_a_t x;
        x = '0;
        x.opcode = d[2:0];
        x.source = d[7:4];
        x.address = d ^ 32'h8000_1000;
        x.data = d;
        return x;
    endfunction

    function automatic tl_b_t mk_b(logic [31:0] d);
        tl_b_t x;
        x = '0;
        x.source = d[3:0];
        x.address = d;
        return x;
    endfunction

    function automatic tl_c_t mk_c(logic [31:0] d);
        tl_c_t x;
        x = '0;
        x.opcode = d[2:0];
        x.address = ~d;
        x.data = d;
        return x;
    endfunction

    function automatic tl_d_t mk_d(logic [31:0] d);
        tl_d_t x;
        x = '0;
        x.source = d[3:0];
        x.sink = d[7:4];
        x.data = d;
        return x;
    endfunction

    function automatic tl_e_t mk_e(logic [31:0] d);
        tl_e_t x;
        x.sink = d[7:0];
        return x;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus_in.a_valid = 1'b1;
        bus_in.a_bits = mk_a(32'hDEAD);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            total++;
            if (bus_out.a_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_a_valid cyc=%0d got=%b exp=0", i, bus_out.a_valid);
            end
            total++;
            if (bus_in.a_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_a_ready cyc=%0d got=%b exp=0", i, bus_in.a_ready);
            end
        end
        rst = 1'b0;
        bus_in.a_valid = 1'b0;
        #1;
        total++;
        if (bus_in.a_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_a_ready got=%b exp=1", bus_in.a_ready);
        end
        total++;
        if ({bus_out.a_valid, bus_in.b_valid, bus_out.c_valid, bus_in.d_valid} !== 4'b0) begin
            bad++;
            $display("FAIL post_reset_valids got=%b exp=0000",
                     {bus_out.a_valid, bus_in.b_valid, bus_out.c_valid, bus_in.d_valid});
        end
        tick();
    endtask

    task automatic test_reset_mid;
        bus_out.a_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus_in.a_valid = 1'b1;
            bus_in.a_bits = mk_a(32'h500 + i);
            tick();
        end
        bus_in.a_valid = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (bus_out.a_valid !== 1'b0 || bus_in.a_ready !== 1'b0) begin
            bad++;
            $display("FAIL midreset_hold got v=%b r=%b exp v=0 r=0", bus_out.a_valid, bus_in.a_ready);
        end
        tick();
        rst = 1'b0;
        bus_out.a_ready = 1'b1;
        #1;
        total++;
        if (bus_out.a_valid !== 1'b0 || bus_in.a_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_flush got v=%b r=%b exp v=0 r=1", bus_out.a_valid, bus_in.a_ready);
        end
        tick();
    endtask

    task automatic test_fill_drain;
        tl_a_t exp;
        bus_out.a_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_in.a_valid = 1'b1;
            bus_in.a_bits = mk_a(32'h11 * (i + 1));
            #1;
            total++;
            if (bus_in.a_ready !== 1'b1) begin
                bad++;
                $display("FAIL fill_ready beat=%0d got=%b exp=1", i, bus_in.a_ready);
            end
            if (bus_in.a_ready === 1'b1) qa.push_back(bus_in.a_bits);
            tick();
        end
        bus_in.a_valid = 1'b0;
        #1;
        total++;
        if (bus_in.a_ready !== 1'b0) begin
            bad++;
            $display("FAIL fill_full_ready got=%b exp=0", bus_in.a_ready);
        end
        bus_out.a_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (bus_out.a_valid !== 1'b1 || qa.size() == 0) begin
                bad++;
                $display("FAIL drain_valid beat=%0d got=%b exp=1", i, bus_out.a_valid);
            end else begin
                exp = qa.pop_front();
                total++;
                if (bus_out.a_bits !== exp) begin
                    bad++;
                    $display("FAIL drain_bits beat=%0d got=%h exp=%h", i, bus_out.a_bits, exp);
                end
            end
            tick();
        end
        #1;
        total++;
        if (bus_out.a_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain_empty got=%b exp=0", bus_out.a_valid);
        end
        tick();
    endtask

    task automatic test_streaming;
        tl_d_t exp;
        logic  exp_v;
        int    got = 0;
        bus_in.d_ready = 1'b1;
        for (int cyc = 0; cyc < 18; cyc++) begin
            if (cyc < 16) begin
                bus_out.d_valid = 1'b1;
                bus_out.d_bits = mk_d({$urandom_range(0, 255), 8'(cyc)});
                qd.push_back(bus_out.d_bits);
            end else begin
                bus_out.d_valid = 1'b0;
            end
            #1;
            if (cyc < 16) begin
                total++;
                if (bus_out.d_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL stream_ready cyc=%0d got=%b exp=1", cyc, bus_out.d_ready);
                end
            end
            exp_v = FLOW ? (cyc < 16) : (cyc >= 1 && cyc <= 16);
            total++;
            if (bus_in.d_valid !== exp_v) begin
                bad++;
                $display("FAIL stream_valid cyc=%0d got=%b exp=%b", cyc, bus_in.d_valid, exp_v);
            end
            if (bus_in.d_valid === 1'b1 && qd.size() > 0) begin
                exp = qd.pop_front();
                got++;
                total++;
                if (bus_in.d_bits !== exp) begin
                    bad++;
                    $display("FAIL stream_bits cyc=%0d got=%h exp=%h", cyc, bus_in.d_bits, exp);
                end
            end
            tick();
        end
        total++;
        if (got != 16 || qd.size() != 0) begin
            bad++;
            $display("FAIL stream_count got=%0d left=%0d exp=16/0", got, qd.size());
        end
    endtask

    task automatic test_full_simul;
        tl_c_t exp;
        bus_out.c_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus_in.c_valid = 1'b1;
            bus_in.c_bits = mk_c(32'h100 + i);
            #1;
            total++;
            if (bus_in.c_ready !== 1'b1) begin
                bad++;
                $display("FAIL cfill_ready beat=%0d got=%b exp=1", i, bus_in.c_ready);
            end
            if (bus_in.c_ready === 1'b1) qc.push_back(bus_in.c_bits);
            tick();
        end
        bus_in.c_valid = 1'b1;
        bus_in.c_bits = mk_c(32'h102);
        bus_out.c_ready = 1'b1;
        #1;
        total++;
        if (bus_in.c_ready !== FLOW) begin
            bad++;
            $display("FAIL csim_ready got=%b exp=%b", bus_in.c_ready, FLOW);
        end
        if (bus_in.c_ready === 1'b1) qc.push_back(bus_in.c_bits);
        exp = qc.pop_front();
        total++;
        if (bus_out.c_valid !== 1'b1 || bus_out.c_bits !== exp) begin
            bad++;
            $display("FAIL csim_pop got v=%b %h exp v=1 %h", bus_out.c_valid, bus_out.c_bits, exp);
        end
        tick();
        bus_out.c_ready = 1'b0;
        bus_in.c_valid = !FLOW;
        #1;
        total++;
        if (bus_in.c_ready !== !FLOW) begin
            bad++;
            $display("FAIL csim_next_ready got=%b exp=%b", bus_in.c_ready, !FLOW);
        end
        if (bus_in.c_valid && bus_in.c_ready === 1'b1) qc.push_back(bus_in.c_bits);
        tick();
        bus_in.c_valid = 1'b0;
        #1;
        total++;
        if (bus_in.c_ready !== 1'b0) begin
            bad++;
            $display("FAIL csim_refull got=%b exp=0", bus_in.c_ready);
        end
        bus_out.c_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (bus_out.c_valid !== 1'b1 || qc.size() == 0) begin
                bad++;
                $display("FAIL cdrain_valid beat=%0d got=%b exp=1", i, bus_out.c_valid);
            end else begin
                exp = qc.pop_front();
                total++;
                if (bus_out.c_bits !== exp) begin
                    bad++;
                    $display("FAIL cdrain_bits beat=%0d got=%h exp=%h", i, bus_out.c_bits, exp);
                end
            end
            tick();
        end
        #1;
        total++;
        if (bus_out.c_valid !== 1'b0 || qc.size() != 0) begin
            bad++;
            $display("FAIL cdrain_empty got=%b left=%0d exp=0", bus_out.c_valid, qc.size());
        end
        tick();
    endtask

    task automatic test_b_path;
        tl_b_t exp;
        exp = mk_b(32'hAB);
        bus_in.b_ready = 1'b1;
        bus_out.b_valid = 1'b1;
        bus_out.b_bits = exp;
        #1;
        total++;
        if (bus_in.b_valid !== FLOW) begin
            bad++;
            $display("FAIL b_first_valid got=%b exp=%b", bus_in.b_valid, FLOW);
        end
        if (bus_in.b_valid === 1'b1) begin
            total++;
            if (bus_in.b_bits !== exp) begin
                bad++;
                $display("FAIL b_first_bits got=%h exp=%h", bus_in.b_bits, exp);
            end
        end
        tick();
        bus_out.b_valid = 1'b0;
        #1;
        total++;
        if (bus_in.b_valid !== !FLOW) begin
            bad++;
            $display("FAIL b_second_valid got=%b exp=%b", bus_in.b_valid, !FLOW);
        end
        if (bus_in.b_valid === 1'b1) begin
            total++;
            if (bus_in.b_bits !== exp) begin
                bad++;
                $display("FAIL b_second_bits got=%h exp=%h", bus_in.b_bits, exp);
            end
        end
        tick();
        #1;
        total++;
        if (bus_in.b_valid !== 1'b0) begin
            bad++;
            $display("FAIL b_empty got=%b exp=0", bus_in.b_valid);
        end
        tick();
    endtask

    task automatic test_wire;
        tl_e_t cur;
        tl_e_t exp;
        int    sent = 0;
        int    got = 0;
        int    cyc = 0;
        cur = mk_e(32'h0);
        while (got < 100 && cyc < 2000) begin
            bus_in.e_valid = (sent < 100) && ($urandom_range(0, 3) != 0);
            bus_in.e_bits = cur;
            bus_out.e_ready = ($urandom_range(0, 3) != 0);
            #1;
            total++;
            if (bus_out.e_valid !== bus_in.e_valid || bus_in.e_ready !== bus_out.e_ready) begin
                bad++;
                $display("FAIL wire_handshake cyc=%0d got v=%b r=%b exp v=%b r=%b", cyc,
                         bus_out.e_valid, bus_in.e_ready, bus_in.e_valid, bus_out.e_ready);
            end
            if (bus_in.e_valid && bus_in.e_ready === 1'b1) begin
                qe.push_back(cur);
                sent++;
                cur = mk_e(32'(sent * 7));
            end
            if (bus_out.e_valid === 1'b1 && bus_out.e_ready) begin
                total++;
                if (qe.size() == 0) begin
                    bad++;
                    $display("FAIL wire_extra cyc=%0d got=%h exp=none", cyc, bus_out.e_bits);
                end else begin
                    exp = qe.pop_front();
                    got++;
                    if (bus_out.e_bits !== exp) begin
                        bad++;
                        $display("FAIL wire_bits cyc=%0d got=%h exp=%h", cyc, bus_out.e_bits, exp);
                    end
                end
            end
            tick();
            cyc++;
        end
        bus_in.e_valid = 1'b0;
        total++;
        if (got != 100) begin
            bad++;
            $display("FAIL wire_count got=%0d exp=100", got);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus_in.a_valid = 1'b0;
        bus_in.a_bits = '0;
        bus_in.c_valid = 1'b0;
        bus_in.c_bits = '0;
        bus_in.e_valid = 1'b0;
        bus_in.e_bits = '0;
        bus_in.b_ready = 1'b1;
        bus_in.d_ready = 1'b1;
        bus_out.a_ready = 1'b1;
        bus_out.c_ready = 1'b1;
        bus_out.e_ready = 1'b1;
        bus_out.b_valid = 1'b0;
        bus_out.b_bits = '0;
        bus_out.d_valid = 1'b0;
        bus_out.d_bits = '0;
        test_reset();
        test_reset_mid();
        test_fill_drain();
        test_streaming();
        test_full_simul();
        test_b_path();
        test_wire();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
